// File: rtl/sec_code_pkg.sv
// Shared definitions for the sequential SEC/SECDED locator: H-matrix column
// generation, status codes and the controller state encoding.
package sec_code_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYND   = 2'd1,
    S_SEARCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_DATA   = 2'b01;
  localparam logic [1:0] ST_CHECK  = 2'b10;
  localparam logic [1:0] ST_UNCORR = 2'b11;

  // Smallest R giving at least k distinct columns of weight >= 2.
  function automatic int calc_r(input int k);
    int r;
    r = 1;
    while (((1 << r) - r - 1) < k) r++;
    return r;
  endfunction

  // Data column i is the i-th value of weight >= 2 in ascending order;
  // check column j is the unit vector 1<<j; anything past the code is zero.
  function automatic logic [31:0] h_col(input int i, input int k, input int r);
    logic [31:0] res;
    int n;
    int pc;
    res = '0;
    n   = 0;
    if (i < k) begin
      for (int v = 0; v < (1 << r); v++) begin
        pc = 0;
        for (int b = 0; b < r; b++) pc += (v >> b) & 1;
        if (pc >= 2) begin
          if (n == i) res = 32'(v);
          n++;
        end
      end
    end else if (i < k + r) begin
      res = 32'(1) << (i - k);
    end
    return res;
  endfunction

endpackage

// File: rtl/sec_col_match.sv
// Compares the syndrome against one group of LANES H columns; columns beyond
// the coded bits never match. Lowest matching lane is reported.
module sec_col_match
  import sec_code_pkg::*;
#(
  parameter int K     = 28,
  parameter int R     = 6,
  parameter int LANES = 4,
  parameter int GW    = 4,
  parameter int LW    = 2
) (
  input  logic [R-1:0]  i_syn,
  input  logic [GW-1:0] i_grp,
  output logic          o_hit,
  output logic [LW-1:0] o_lane
);

  localparam int NB   = K + R;
  localparam int NPAD = (1 << GW) * LANES;
  localparam int IW   = $clog2(NPAD);

  logic [R-1:0] w_col [NPAD];
  logic         w_ok  [NPAD];
  logic [IW-1:0] w_idx;

  // Table padded to every reachable group index so lookups never go out of range.
  for (genvar c = 0; c < NPAD; c++) begin : g_tab
    assign w_col[c] = R'(h_col(c, K, R));
    assign w_ok[c]  = (c < NB);
  end

  always_comb begin
    o_hit  = 1'b0;
    o_lane = '0;
    w_idx  = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      w_idx = IW'(int'(i_grp) * LANES + l);
      if (w_ok[w_idx] && (w_col[w_idx] == i_syn)) begin
        o_hit  = 1'b1;
        o_lane = LW'(l);
      end
    end
  end

endmodule

// File: rtl/sec_locator_seq.sv
// Handshaked SEC/SECDED locator: latch a codeword, form its syndrome, then
// search the H matrix LANES columns per cycle and return corrected data.
module sec_locator_seq
  import sec_code_pkg::*;
#(
  parameter  int K      = 28,
  parameter  int LANES  = 4,
  parameter  int SECDED = 1,
  localparam int R      = calc_r(K),
  localparam int CW     = K + R + SECDED,
  localparam int PW     = $clog2(CW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] cw_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  data_out,
  output logic [PW-1:0] err_pos,
  output logic [1:0]    status
);

  localparam int NB = K + R;
  localparam int G  = (NB + LANES - 1) / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t        r_state;
  logic [CW-1:0] r_cw;
  logic [R-1:0]  r_syn;
  logic [GW-1:0] r_grp;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [K-1:0]  r_data_out;
  logic [PW-1:0] r_err_pos;
  logic [1:0]    r_status;

  logic [R-1:0]  w_hcol [NB];
  logic [R-1:0]  w_syn;
  logic          w_op;
  logic          w_hit;
  logic [LW-1:0] w_lane;
  logic [31:0]   w_hit_col;
  logic [K-1:0]  w_fix_data;

  for (genvar b = 0; b < NB; b++) begin : g_hcol
    assign w_hcol[b] = R'(h_col(b, K, R));
  end

  always_comb begin
    w_syn = '0;
    for (int b = 0; b < NB; b++) begin
      if (r_cw[b]) w_syn = w_syn ^ w_hcol[b];
    end
  end

  // Without SECDED the overall parity is treated as always even.
  assign w_op = (SECDED != 0) ? (^r_cw) : 1'b0;

  sec_col_match #(
    .K     (K),
    .R     (R),
    .LANES (LANES),
    .GW    (GW),
    .LW    (LW)
  ) u_match (
    .i_syn  (r_syn),
    .i_grp  (r_grp),
    .o_hit  (w_hit),
    .o_lane (w_lane)
  );

  assign w_hit_col  = 32'(r_grp) * 32'(LANES) + 32'(w_lane);
  assign w_fix_data = r_cw[K-1:0] ^
                      ((w_hit_col < 32'(K)) ? ({{(K-1){1'b0}}, 1'b1} << w_hit_col) : '0);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid and the result stay stable until out_ready is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cw        <= '0;
      r_syn       <= '0;
      r_grp       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_err_pos   <= '0;
      r_status    <= ST_CLEAN;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_cw       <= cw_in;
            r_in_ready <= 1'b0;
            r_state    <= S_SYND;
          end
        end
        S_SYND: begin
          r_syn <= w_syn;
          r_grp <= '0;
          if (w_syn == '0 && !w_op) begin
            r_data_out  <= r_cw[K-1:0];
            r_err_pos   <= '0;
            r_status    <= ST_CLEAN;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_syn == '0) begin
            r_data_out  <= r_cw[K-1:0];
            r_err_pos   <= PW'(CW - 1);
            r_status    <= ST_CHECK;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (SECDED != 0 && !w_op) begin
            r_data_out  <= r_cw[K-1:0];
            r_err_pos   <= '0;
            r_status    <= ST_UNCORR;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_data_out  <= w_fix_data;
            r_err_pos   <= PW'(w_hit_col);
            r_status    <= (w_hit_col < 32'(K)) ? ST_DATA : ST_CHECK;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_grp == GW'(G - 1)) begin
            r_data_out  <= r_cw[K-1:0];
            r_err_pos   <= '0;
            r_status    <= ST_UNCORR;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign err_pos   = r_err_pos;
  assign status    = r_status;

endmodule

// File: tb/tb_sec_locator_seq.sv
// Directed bench for sec_locator_seq at default parameters (K=28, R=6, CW=35,
// LANES=4, G=9): codewords are built from a hand-listed H column table.
module tb_sec_locator_seq;

  localparam int K  = 28;
  localparam int CW = 35;
  localparam int PW = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] cw_in;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  data_out;
  logic [PW-1:0] err_pos;
  logic [1:0]    status;

  int n_checks = 0;
  int n_errors = 0;

  // Weight>=2 six-bit values in ascending order: columns of data bits 0..27.
  localparam int DCOL [28] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19,
                               20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 33, 34};

  localparam logic [K-1:0] D0 = 28'h0ABCDEF;

  sec_locator_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cw_in     (cw_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err_pos   (err_pos),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] encode(input logic [K-1:0] d);
    logic [5:0] syn;
    syn = '0;
    for (int i = 0; i < K; i++) begin
      if (d[i]) syn = syn ^ 6'(DCOL[i]);
    end
    return {^{syn, d}, syn, d};
  endfunction

  // Offer a codeword, then count edges from accept until out_valid rises.
  task automatic start_job(input logic [CW-1:0] cw, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    cw_in    = cw;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cw_in    = ~cw;
    check_val({tag, "_busy"}, 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic finish_job(input logic [K-1:0] exp_d, input int exp_pos,
                            input logic [1:0] exp_st, input string tag);
    check_val({tag, "_data"}, 64'(data_out), 64'(exp_d));
    check_val({tag, "_pos"},  64'(err_pos),  64'(exp_pos));
    check_val({tag, "_st"},   64'(status),   64'(exp_st));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_idle_rdy"}, 64'(in_ready),  64'd1);
    check_val({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
  endtask

  logic [CW-1:0] cw0;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cw_in     = '0;
    cw0       = encode(D0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rdy",  64'(in_ready),  64'd1);
    check_val("rst_vld",  64'(out_valid), 64'd0);
    check_val("rst_data", 64'(data_out),  64'd0);
    check_val("rst_pos",  64'(err_pos),   64'd0);
    check_val("rst_st",   64'(status),    64'd0);
    @(negedge clk);
    rst = 1'b0;

    start_job(cw0, 2, "clean");
    finish_job(D0, 0, 2'b00, "clean");

    start_job(cw0 ^ (35'd1 << 0), 3, "d0");
    finish_job(D0, 0, 2'b01, "d0");

    start_job(cw0 ^ (35'd1 << 15), 6, "d15");
    finish_job(D0, 15, 2'b01, "d15");

    start_job(cw0 ^ (35'd1 << 27), 9, "d27");
    finish_job(D0, 27, 2'b01, "d27");

    start_job(cw0 ^ (35'd1 << 29), 10, "c29");
    finish_job(D0, 29, 2'b10, "c29");

    start_job(cw0 ^ (35'd1 << 33), 11, "c33");
    finish_job(D0, 33, 2'b10, "c33");

    start_job(cw0 ^ (35'd1 << 34), 2, "p34");
    finish_job(D0, 34, 2'b10, "p34");

    start_job(cw0 ^ (35'd1 << 3) ^ (35'd1 << 10), 2, "dbl");
    finish_job(D0 ^ 28'h0000408, 0, 2'b11, "dbl");

    // All six check bits plus parity: syndrome 63 is no column, parity odd.
    start_job(cw0 ^ {1'b1, 6'h3F, 28'h0}, 11, "nomatch");
    finish_job(D0, 0, 2'b11, "nomatch");

    // Hold the result in DONE while a second codeword is offered.
    start_job(cw0, 2, "hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      cw_in    = cw0 ^ (35'd1 << 5);
      @(posedge clk);
      #1;
      check_val("hold_vld",  64'(out_valid), 64'd1);
      check_val("hold_rdy",  64'(in_ready),  64'd0);
      check_val("hold_data", 64'(data_out),  64'(D0));
      check_val("hold_st",   64'(status),    64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("hold_rel_rdy", 64'(in_ready),  64'd1);
    check_val("hold_rel_vld", 64'(out_valid), 64'd0);

    // Reset while searching group 3 (error at bit 15 would match next edge).
    @(negedge clk);
    cw_in    = cw0 ^ (35'd1 << 15);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_rdy", 64'(in_ready),  64'd1);
    check_val("abort_vld", 64'(out_valid), 64'd0);
    check_val("abort_st",  64'(status),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("abort_quiet", 64'(out_valid), 64'd0);
    end

    start_job(encode(28'h5A5A5A5), 2, "post");
    finish_job(28'h5A5A5A5, 0, 2'b00, "post");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
